// File: rtl/forward_hazard_unit_pkg.sv
// Shared definitions for the forward/hazard unit: operand-select codes,
// register-index width, pipeline-slot record and FSM state constants.
package forward_hazard_unit_pkg;

  localparam int REG_W = 4;

  typedef logic [REG_W-1:0] reg_idx_t;

  // Operand select codes driven on forward_a / forward_b
  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_ADDER = 2'd1;
  localparam logic [1:0] FWD_WB    = 2'd2;

  // FSM state enumeration (debug-visible only)
  typedef logic [0:0] fhu_state_t;
  localparam fhu_state_t ST_RUN  = 1'b0;
  localparam fhu_state_t ST_HOLD = 1'b1;

  // Execute-stage record: destination, write enable, load flag
  typedef struct packed {
    reg_idx_t rd;
    logic     we;
    logic     ld;
  } ex_slot_t;

  // True when a used, valid source operand names a live producer.
  // Register 0 is hard-wired and never produces a match.
  function automatic logic idx_hit(
    input logic     used,
    input logic     valid,
    input reg_idx_t rs,
    input reg_idx_t rd,
    input logic     we
  );
    return used & valid & we & (rs != {REG_W{1'b0}}) & (rs == rd);
  endfunction

endpackage

// File: rtl/forward_hazard_unit_fhu_match.sv
// Per-operand dependency check: operand select plus the two stall causes
// (load in execute, and writeback hit when writeback forwarding is absent).
// Build option: FHU_WB_FORWARD_EN enables forwarding from the writeback stage.
module fhu_match
  import forward_hazard_unit_pkg::*;
(
  input  logic       id_valid,
  input  logic       use_rs,
  input  reg_idx_t   rs,
  input  reg_idx_t   ex_rd,
  input  logic       ex_we,
  input  logic       ex_ld,
  input  reg_idx_t   wb_rd,
  input  logic       wb_we,
  output logic [1:0] sel,
  output logic       load_hit,
  output logic       wb_hit
);

  logic ex_match_s;
  logic wb_match_s;

  assign ex_match_s = idx_hit(use_rs, id_valid, rs, ex_rd, ex_we);
  assign wb_match_s = idx_hit(use_rs, id_valid, rs, wb_rd, wb_we);

  // Select source for this operand; EX result wins over WB result
  always_comb begin
    sel      = FWD_RF;
    load_hit = 1'b0;
    wb_hit   = 1'b0;
    if (ex_match_s) begin
      if (ex_ld) begin
        load_hit = 1'b1;
      end else begin
        sel = FWD_ADDER;
      end
    end else if (wb_match_s) begin
`ifdef FHU_WB_FORWARD_EN
      sel = FWD_WB;
`else
      // No WB bypass path: wait one cycle for the register file write
      wb_hit = 1'b1;
`endif
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding and load-use hazard unit for a short in-order pipeline.
// Tracks the execute and writeback destinations and drives operand selects
// and the decode stall. Build option: FHU_WB_FORWARD_EN (writeback bypass).
module forward_hazard_unit
  import forward_hazard_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [3:0]  id_rs_a,
  input  logic [3:0]  id_rs_b,
  input  logic        id_use_a,
  input  logic        id_use_b,
  input  logic [3:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        branch_flush,
  output logic [1:0]  forward_a,
  output logic [1:0]  forward_b,
  output logic        stall
);

  ex_slot_t   ex_r;
  reg_idx_t   wb_rd_r;
  logic       wb_we_r;
  fhu_state_t state_r;

  logic [1:0] sel_a_s;
  logic [1:0] sel_b_s;
  logic       load_hit_a_s;
  logic       load_hit_b_s;
  logic       wb_hit_a_s;
  logic       wb_hit_b_s;
  logic       stall_s;
  logic       bubble_s;
  logic       hold_req_s;

  fhu_match u_match_a (
    .id_valid (id_valid),
    .use_rs   (id_use_a),
    .rs       (id_rs_a),
    .ex_rd    (ex_r.rd),
    .ex_we    (ex_r.we),
    .ex_ld    (ex_r.ld),
    .wb_rd    (wb_rd_r),
    .wb_we    (wb_we_r),
    .sel      (sel_a_s),
    .load_hit (load_hit_a_s),
    .wb_hit   (wb_hit_a_s)
  );

  fhu_match u_match_b (
    .id_valid (id_valid),
    .use_rs   (id_use_b),
    .rs       (id_rs_b),
    .ex_rd    (ex_r.rd),
    .ex_we    (ex_r.we),
    .ex_ld    (ex_r.ld),
    .wb_rd    (wb_rd_r),
    .wb_we    (wb_we_r),
    .sel      (sel_b_s),
    .load_hit (load_hit_b_s),
    .wb_hit   (wb_hit_b_s)
  );

  // Stall and operand selects; reset forces the idle values directly
  always_comb begin
    stall_s   = 1'b0;
    forward_a = FWD_RF;
    forward_b = FWD_RF;
    if (rst) begin
      stall_s = 1'b0;
    end else begin
      stall_s = load_hit_a_s | load_hit_b_s | wb_hit_a_s | wb_hit_b_s;
      if (!stall_s) begin
        forward_a = sel_a_s;
        forward_b = sel_b_s;
      end else begin
        forward_a = FWD_RF;
        forward_b = FWD_RF;
      end
    end
  end

  assign stall      = stall_s;
  assign bubble_s   = stall_s | branch_flush;
  // Flush takes precedence: a flushed cycle is not treated as a stall
  assign hold_req_s = stall_s & ~branch_flush;

  // Advance execute/writeback tracking; inject a bubble on stall or flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_r    <= '{rd: 4'd0, we: 1'b0, ld: 1'b0};
      wb_rd_r <= 4'd0;
      wb_we_r <= 1'b0;
    end else begin
      wb_rd_r <= ex_r.rd;
      wb_we_r <= ex_r.we;
      if (bubble_s) begin
        ex_r <= '{rd: 4'd0, we: 1'b0, ld: 1'b0};
      end else begin
        ex_r <= '{rd: id_rd,
                  we: id_reg_write & id_valid,
                  ld: id_mem_read & id_valid};
      end
    end
  end

  // Debug-visible RUN/HOLD tracker; drives no output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      case (state_r)
        ST_RUN:  state_r <= hold_req_s ? ST_HOLD : ST_RUN;
        ST_HOLD: state_r <= hold_req_s ? ST_HOLD : ST_RUN;
        default: state_r <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Self-checking bench for forward_hazard_unit: a producer-history model
// checked every cycle, plus hand-computed expectations for key scenarios.
// Honours FHU_WB_FORWARD_EN in the same way as the design build.
module tb_forward_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_rs_a;
  logic [3:0] id_rs_b;
  logic       id_use_a;
  logic       id_use_b;
  logic [3:0] id_rd;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       branch_flush;
  logic [1:0] forward_a;
  logic [1:0] forward_b;
  logic       stall;

  int checks = 0;
  int errors = 0;

  forward_hazard_unit dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs_a      (id_rs_a),
    .id_rs_b      (id_rs_b),
    .id_use_a     (id_use_a),
    .id_use_b     (id_use_b),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .branch_flush (branch_flush),
    .forward_a    (forward_a),
    .forward_b    (forward_b),
    .stall        (stall)
  );

  always #5 clk = ~clk;

  // Model: the two most recently issued producers, youngest first.
  typedef struct {
    int  rd;
    bit  writes;
    bit  is_load;
  } producer_t;

  producer_t hist_m [2];

  // Decide one operand: returns {hazard, select}
  function automatic int op_expect(bit used, int rs, output bit hazard);
    hazard = 0;
    if (!used || !id_valid || rs == 0) return 0;
    for (int age = 0; age < 2; age++) begin
      if (hist_m[age].writes && hist_m[age].rd == rs) begin
        if (age == 0) begin
          if (hist_m[age].is_load) begin
            hazard = 1;
            return 0;
          end
          return 1;
        end
`ifdef FHU_WB_FORWARD_EN
        return 2;
`else
        hazard = 1;
        return 0;
`endif
      end
    end
    return 0;
  endfunction

  function automatic bit model_stall();
    bit ha, hb;
    int s;
    if (rst) return 0;
    s = op_expect(id_use_a, int'(id_rs_a), ha);
    s = op_expect(id_use_b, int'(id_rs_b), hb);
    return ha | hb;
  endfunction

  function automatic int model_fwd(bit which_b);
    bit h;
    int s;
    if (rst || model_stall()) return 0;
    if (which_b) s = op_expect(id_use_b, int'(id_rs_b), h);
    else         s = op_expect(id_use_a, int'(id_rs_a), h);
    return s;
  endfunction

  // Model history update on the clock; cleared asynchronously by reset
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_m[0] <= '{rd: 0, writes: 0, is_load: 0};
      hist_m[1] <= '{rd: 0, writes: 0, is_load: 0};
    end else begin
      hist_m[1] <= hist_m[0];
      if (model_stall() || branch_flush)
        hist_m[0] <= '{rd: 0, writes: 0, is_load: 0};
      else
        hist_m[0] <= '{rd: int'(id_rd), writes: id_reg_write && id_valid,
                       is_load: id_mem_read && id_valid};
    end
  end

  // Every-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    checks = checks + 3;
    if (int'(stall) != int'(model_stall())) begin
      errors++;
      $display("FAIL model_stall t=%0t got=%0d exp=%0d", $time, stall, model_stall());
    end
    if (int'(forward_a) != model_fwd(1'b0)) begin
      errors++;
      $display("FAIL model_fwd_a t=%0t got=%0d exp=%0d", $time, forward_a, model_fwd(1'b0));
    end
    if (int'(forward_b) != model_fwd(1'b1)) begin
      errors++;
      $display("FAIL model_fwd_b t=%0t got=%0d exp=%0d", $time, forward_b, model_fwd(1'b1));
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  task automatic drive(input bit v, input int ra, input int rb, input bit ua,
                       input bit ub, input int rd, input bit we, input bit ld,
                       input bit fl);
    id_valid     = v;
    id_rs_a      = 4'(ra);
    id_rs_b      = 4'(rb);
    id_use_a     = ua;
    id_use_b     = ub;
    id_rd        = 4'(rd);
    id_reg_write = we;
    id_mem_read  = ld;
    branch_flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("reset_stall", int'(stall), 0);
    chk("reset_fwd_a", int'(forward_a), 0);
    chk("reset_fwd_b", int'(forward_b), 0);
    rst = 1'b0;
    tick();

    // ADD r3 ; ADD using r3 as A -> adder forwarding
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
    tick();
    drive(1, 3, 0, 1, 0, 4, 1, 0, 0);
    sample();
    chk("ex_fwd_a", int'(forward_a), 1);
    chk("ex_fwd_stall", int'(stall), 0);
    tick();
    drain();

    // ADD r5 ; unrelated ; use r5 as B
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    tick();
    drive(1, 7, 8, 1, 1, 6, 1, 0, 0);
    tick();
    drive(1, 0, 5, 0, 1, 9, 1, 0, 0);
    sample();
`ifdef FHU_WB_FORWARD_EN
    chk("wb_fwd_b", int'(forward_b), 2);
    chk("wb_fwd_stall", int'(stall), 0);
`else
    chk("wb_nofwd_stall", int'(stall), 1);
    chk("wb_nofwd_b", int'(forward_b), 0);
    tick();
    sample();
    chk("wb_nofwd_stall2", int'(stall), 0);
    chk("wb_nofwd_b2", int'(forward_b), 0);
`endif
    tick();
    drain();

    // LOAD r2 ; use r2 as A and B
    drive(1, 0, 0, 0, 0, 2, 1, 1, 0);
    tick();
    drive(1, 2, 2, 1, 1, 10, 1, 0, 0);
    sample();
    chk("lu_stall", int'(stall), 1);
    chk("lu_fwd_a", int'(forward_a), 0);
    tick();
    sample();
`ifdef FHU_WB_FORWARD_EN
    chk("lu_stall2", int'(stall), 0);
    chk("lu_fwd_a2", int'(forward_a), 2);
    chk("lu_fwd_b2", int'(forward_b), 2);
`else
    chk("lu_stall2", int'(stall), 1);
    chk("lu_fwd_a2", int'(forward_a), 0);
    tick();
    sample();
    chk("lu_stall3", int'(stall), 0);
    chk("lu_fwd_b3", int'(forward_b), 0);
`endif
    tick();
    drain();

    // Write r0 ; use r0 -> never matches
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    drive(1, 0, 0, 1, 1, 1, 1, 0, 0);
    sample();
    chk("r0_fwd_a", int'(forward_a), 0);
    chk("r0_stall", int'(stall), 0);
    tick();
    drain();

    // Load-use with simultaneous flush: flushed producer r12 must vanish
    drive(1, 0, 0, 0, 0, 2, 1, 1, 0);
    tick();
    drive(1, 2, 0, 1, 0, 12, 1, 0, 1);
    sample();
    chk("flush_stall_comb", int'(stall), 1);
    tick();
    drive(1, 12, 0, 1, 0, 13, 1, 0, 0);
    sample();
    chk("flush_bubble_fwd_a", int'(forward_a), 0);
    chk("flush_no_stall", int'(stall), 0);
    tick();
    drain();

    // Reset pulse in the middle of a load-use stall
    drive(1, 0, 0, 0, 0, 2, 1, 1, 0);
    tick();
    drive(1, 2, 2, 1, 1, 14, 1, 0, 0);
    sample();
    chk("pre_rst_stall", int'(stall), 1);
    rst = 1'b1;
    #1;
    chk("rst_stall", int'(stall), 0);
    chk("rst_fwd_a", int'(forward_a), 0);
    chk("rst_fwd_b", int'(forward_b), 0);
    tick();
    rst = 1'b0;
    sample();
    chk("post_rst_stall", int'(stall), 0);
    tick();
    drain();

    // Mixed pattern stream, checked against the model every cycle
    for (int i = 0; i < 48; i++) begin
      drive((i % 6) != 5, (i * 3) % 4, (i * 5 + 1) % 4, (i % 3) != 0,
            (i % 4) != 1, (i + 1) % 4, (i % 5) != 2, (i % 4) == 0,
            (i % 7) == 3);
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
